// File: rtl/spi_tb_top.sv
// SPI mode-0 slave that decodes 48-bit LSB-first frames into single APB
// transfers against an internal word-addressed register map.
module apb_rm #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter bit USE_MEM = 1'b0
) (
  input  logic              clk,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);
  assign pready  = psel & penable;
  assign pslverr = 1'b0;

  generate
    if (USE_MEM) begin : g_full
      logic [DATA_W-1:0] mem [2**ADDR_W];
      always_ff @(posedge clk) begin
        if (pready && pwrite) mem[paddr] <= pwdata;
      end
      assign prdata = mem[paddr];
    end else begin : g_small
      // Only words 0..31 exist; everything above reads 0 and drops writes.
      logic [DATA_W-1:0] mem [32];
      logic              hit;
      assign hit = (paddr[ADDR_W-1:5] == '0);
      always_ff @(posedge clk) begin
        if (pready && pwrite && hit) mem[paddr[4:0]] <= pwdata;
      end
      assign prdata = hit ? mem[paddr[4:0]] : '0;
    end
  endgenerate
endmodule

module spi_tb_top #(
  parameter int         ADDR_W  = 20,
  parameter int         DATA_W  = 16,
  parameter bit         USE_MEM = 1'b0,
  parameter logic [7:0] HDR     = 8'h17
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_sclk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic frame_done,
  output logic frame_err
);
  localparam int FRAME_W = 32 + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int AIDX_W  = $clog2(ADDR_W);
  localparam int DIDX_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] ADDR_END = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] WR_POS   = CNT_W'(22);
  localparam logic [CNT_W-1:0] HDR_POS  = CNT_W'(24);
  localparam logic [CNT_W-1:0] DATA_POS = CNT_W'(32);
  localparam logic [CNT_W-1:0] FRM_END  = CNT_W'(FRAME_W);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} frm_state_t;
  typedef enum logic [1:0] {A_IDLE, A_SETUP, A_ACCESS} apb_state_t;

  frm_state_t frm_state, frm_nxt;
  apb_state_t apb_state, apb_nxt;

  logic [2:0] sclk_sync, cs_sync;
  logic [1:0] mosi_sync;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall, cs_low, mosi_s, take_bit;

  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] addr_p0;
  logic              wr_p0;
  logic [7:0]        hdr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [DATA_W-1:0] rdata_p1;

  logic              apb_go_c, apb_wr_c, done_c, err_c, apb_go_p1;
  logic              psel, penable, pwrite, pready, pslverr, apb_done;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata, prdata;

  // Synchronizers are left out of reset so a reset mid-frame never fakes a CS edge.
  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[1:0], spi_sclk};
    cs_sync   <= {cs_sync[1:0], spi_cs_n};
    mosi_sync <= {mosi_sync[0], spi_mosi};
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  assign cs_low    = ~cs_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign take_bit  = sclk_rise && cs_low && (frm_state == S_ADDR || frm_state == S_DATA)
                     && (bit_cnt < FRM_END);

  always_comb begin
    frm_nxt  = frm_state;
    apb_go_c = 1'b0;
    apb_wr_c = 1'b0;
    done_c   = 1'b0;
    err_c    = 1'b0;
    case (frm_state)
      S_IDLE: if (cs_fall) frm_nxt = S_ADDR;
      S_ADDR: begin
        if (cs_rise) begin
          err_c   = 1'b1;
          frm_nxt = S_IDLE;
        end else if (bit_cnt == DATA_POS) begin
          if (hdr_p0 != HDR) begin
            err_c   = 1'b1;
            frm_nxt = S_DONE;
          end else begin
            frm_nxt  = S_DATA;
            apb_go_c = ~wr_p0;
          end
        end
      end
      S_DATA: begin
        if (cs_rise) begin
          err_c   = 1'b1;
          frm_nxt = S_IDLE;
        end else if (bit_cnt == FRM_END) begin
          frm_nxt  = S_DONE;
          apb_go_c = wr_p0;
          apb_wr_c = wr_p0;
          done_c   = ~wr_p0;
        end
      end
      S_DONE: if (cs_rise) frm_nxt = S_IDLE;
      default: frm_nxt = S_IDLE;
    endcase
  end

  // Stage p0: frame fields captured bit by bit from the synchronized MOSI
  always_ff @(posedge clk) begin
    if (rst) begin
      frm_state <= S_IDLE;
      bit_cnt   <= '0;
      addr_p0   <= '0;
      wr_p0     <= 1'b0;
      hdr_p0    <= '0;
      wdata_p0  <= '0;
    end else begin
      frm_state <= frm_nxt;
      if (frm_state == S_IDLE) begin
        bit_cnt <= '0;
      end else if (take_bit) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        if (bit_cnt < ADDR_END)                            addr_p0[bit_cnt[AIDX_W-1:0]]  <= mosi_s;
        else if (bit_cnt == WR_POS)                        wr_p0                         <= mosi_s;
        else if (bit_cnt >= HDR_POS && bit_cnt < DATA_POS) hdr_p0[bit_cnt[2:0]]          <= mosi_s;
        else if (bit_cnt >= DATA_POS)                      wdata_p0[bit_cnt[DIDX_W-1:0]] <= mosi_s;
      end
    end
  end

  // Stage p1: APB request registered, then run through SETUP/ACCESS
  always_ff @(posedge clk) begin
    if (rst) begin
      apb_go_p1  <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      apb_state  <= A_IDLE;
    end else begin
      apb_go_p1 <= apb_go_c;
      if (apb_go_c) begin
        paddr  <= addr_p0;
        pwrite <= apb_wr_c;
        pwdata <= wdata_p0;
      end
      frame_done <= done_c | (apb_done & pwrite);
      frame_err  <= err_c;
      apb_state  <= apb_nxt;
    end
  end

  always_comb begin
    apb_nxt = apb_state;
    case (apb_state)
      A_IDLE:   if (apb_go_p1) apb_nxt = A_SETUP;
      A_SETUP:  apb_nxt = A_ACCESS;
      A_ACCESS: if (pready) apb_nxt = A_IDLE;
      default:  apb_nxt = A_IDLE;
    endcase
  end

  assign psel     = (apb_state != A_IDLE);
  assign penable  = (apb_state == A_ACCESS);
  assign apb_done = penable & pready;

  // Read data only reaches MISO while the frame that issued it is still in DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_p1 <= '0;
      spi_miso <= 1'b0;
    end else begin
      if (apb_done && !pwrite && !pslverr) rdata_p1 <= prdata;
      if (frm_state != S_DATA || !cs_low || wr_p0 || bit_cnt >= FRM_END)
        spi_miso <= 1'b0;
      else if (sclk_fall)
        spi_miso <= rdata_p1[bit_cnt[DIDX_W-1:0]];
    end
  end

  apb_rm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .USE_MEM(USE_MEM)) apb_rm_i (
    .clk     (clk),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );
endmodule

// File: tb/tb_spi_tb_top.sv
// Scoreboard bench for spi_tb_top: one full-memory and one 32-word instance
// share the SPI bus; a monitor pops expected frame outcomes on done/err pulses.
module tb_spi_tb_top;
  localparam int HALF = 100;
  localparam logic [1:0] K_NONE = 2'd0, K_WR = 2'd1, K_RD = 2'd2, K_ERR = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic miso_f, done_f, err_f, miso_s, done_s, err_s;
  logic [47:0] cap_f = '0, cap_s = '0;
  exp_t q_f[$], q_s[$];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  spi_tb_top #(.ADDR_W(20), .DATA_W(16), .USE_MEM(1'b1), .HDR(8'h17)) dut_full (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(miso_f), .frame_done(done_f), .frame_err(err_f)
  );

  spi_tb_top #(.ADDR_W(20), .DATA_W(16), .USE_MEM(1'b0), .HDR(8'h17)) dut_small (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(miso_s), .frame_done(done_s), .frame_err(err_s)
  );

  task automatic check_evt(input exp_t e, input logic d, input logic er,
                           input logic [47:0] cap, input string nm);
    logic exp_err;
    exp_err = (e.kind == K_ERR);
    total++;
    if (er !== exp_err || d !== !exp_err) begin
      bad++;
      $display("FAIL %s_event: done=%0b err=%0b required err=%0b", nm, d, er, exp_err);
    end
    if (!exp_err) begin
      total++;
      if (cap !== {e.data, 32'h0}) begin
        bad++;
        $display("FAIL %s_miso: got %h required %h", nm, cap, {e.data, 32'h0});
      end
    end
  endtask

  always @(negedge clk) begin
    if (done_f || err_f) begin
      if (q_f.size() == 0) begin
        total++; bad++;
        $display("FAIL full_unexpected: done=%0b err=%0b required no event", done_f, err_f);
      end else check_evt(q_f.pop_front(), done_f, err_f, cap_f, "full");
    end
    if (done_s || err_s) begin
      if (q_s.size() == 0) begin
        total++; bad++;
        $display("FAIL small_unexpected: done=%0b err=%0b required no event", done_s, err_s);
      end else check_evt(q_s.pop_front(), done_s, err_s, cap_s, "small");
    end
  end

  task automatic run(input logic [47:0] fr, input int nbits, input int gap,
                     input logic [1:0] kf, input logic [15:0] df,
                     input logic [1:0] ks, input logic [15:0] ds, input int rst_at);
    exp_t e;
    if (kf != K_NONE) begin e.kind = kf; e.data = df; q_f.push_back(e); end
    if (ks != K_NONE) begin e.kind = ks; e.data = ds; q_s.push_back(e); end
    cap_f = '0;
    cap_s = '0;
    spi_cs_n = 1'b0;
    #HALF;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = fr[i];
      if (i == rst_at) begin
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
          #10;
          total++;
          if ({miso_f, done_f, err_f, miso_s, done_s, err_s} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b required 000000",
                     {miso_f, done_f, err_f, miso_s, done_s, err_s});
          end
        end
        rst = 1'b0;
      end
      #HALF;
      spi_sclk = 1'b1;
      cap_f[i] = miso_f;
      cap_s[i] = miso_s;
      #HALF;
      spi_sclk = 1'b0;
    end
    #HALF;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    #(gap * 10);
  endtask

  initial begin
    #52;
    total++;
    if ({miso_f, done_f, err_f, miso_s, done_s, err_s} !== 6'b0) begin
      bad++;
      $display("FAIL reset_state: got %b required 000000",
               {miso_f, done_f, err_f, miso_s, done_s, err_s});
    end
    rst = 1'b0;
    #100;
    //   frame              bits gap  full: kind/data    small: kind/data   rst_at
    run(48'hccdf_1745ad01, 48, 20, K_WR,  16'h0,    K_WR,  16'h0,    -1);
    run(48'h0000_1705ad01, 48, 20, K_RD,  16'hccdf, K_RD,  16'h0,    -1);
    run(48'h1234_1845ad01, 48, 20, K_ERR, 16'h0,    K_ERR, 16'h0,    -1);
    run(48'h0000_1705ad01, 48, 20, K_RD,  16'hccdf, K_RD,  16'h0,    -1);
    run(48'h5555_1745ad02, 48, 20, K_WR,  16'h0,    K_WR,  16'h0,    -1);
    run(48'hbeef_1745ad02, 40, 20, K_ERR, 16'h0,    K_ERR, 16'h0,    -1);
    run(48'h0000_1705ad02, 48, 20, K_RD,  16'h5555, K_RD,  16'h0,    -1);
    run(48'ha5a5_1740001f, 48, 20, K_WR,  16'h0,    K_WR,  16'h0,    -1);
    run(48'h0000_1700001f, 48, 20, K_RD,  16'ha5a5, K_RD,  16'ha5a5, -1);
    run(48'h7e7e_17400020, 48, 20, K_WR,  16'h0,    K_WR,  16'h0,    -1);
    run(48'h0000_17000020, 48, 20, K_RD,  16'h7e7e, K_RD,  16'h0,    -1);
    run(48'hdead_1745ad03, 48, 4,  K_WR,  16'h0,    K_WR,  16'h0,    -1);
    run(48'hdaad_1745ad03, 48, 4,  K_WR,  16'h0,    K_WR,  16'h0,    -1);
    run(48'h0000_1705ad03, 48, 20, K_RD,  16'hdaad, K_RD,  16'h0,    -1);
    run(48'h1111_1745ad01, 48, 20, K_NONE, 16'h0,   K_NONE, 16'h0,   20);
    run(48'h0000_1705ad01, 48, 20, K_RD,  16'hccdf, K_RD,  16'h0,    -1);
    run(48'h0000_1705ad01, 40, 20, K_ERR, 16'h0,    K_ERR, 16'h0,    -1);
    run(48'h0000_1700001f, 48, 20, K_RD,  16'ha5a5, K_RD,  16'ha5a5, -1);
    #500;
    total++;
    if (q_f.size() != 0) begin
      bad++;
      $display("FAIL full_pending: got %0d outstanding required 0", q_f.size());
    end
    total++;
    if (q_s.size() != 0) begin
      bad++;
      $display("FAIL small_pending: got %0d outstanding required 0", q_s.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_tb_top.md
# spi_tb_top

SPI-to-register-map bridge: an SPI mode-0 slave front end decodes 48-bit frames and issues single APB transfers to an internal 16-bit register map, `apb_rm_i`, which is backed by a word memory. It is the top-level block driven by the SPI-master verification model, giving an external host read/write access to the register space over four wires.

## Interface
- `ADDR_W`, 20: register address width, word addressed.
- `DATA_W`, 16: register data width.
- `USE_MEM`, 0: selects the register-map backing store.
  - 1: full 2^ADDR_W-word memory.
  - 0: only words 0..31 are implemented; other addresses read 0 and ignore writes.
- `HDR`, 8'h17: required frame header byte.
- `clk`  in  1  system clock; one clock domain; all logic runs on it.
- `rst`  in  1  synchronous, active-high reset.
- `spi_sclk`  in  1  SPI clock, asynchronous to `clk`.
- `spi_cs_n`  in  1  chip select, active low.
- `spi_mosi`  in  1  master-out data.
- `spi_miso`  out  1  slave-out data; reset 0.
- `frame_done`  out  1  1-cycle pulse per valid completed frame; reset 0.
- `frame_err`  out  1  1-cycle pulse on header mismatch or short frame; reset 0.

## Operation
- Synchronization:
  - `spi_sclk`, `spi_cs_n` and `spi_mosi` each pass through a 2-flop synchronizer.
  - Edges are detected in the `clk` domain.
- SPI mode 0:
  - MOSI is sampled on the SCLK rising edge.
  - MISO is updated on the SCLK falling edge.
  - Bit order is LSB first.
- Frame layout (48 bits, bit 0 sent first):
  - [19:0] address.
  - [20] reserved.
  - [21] reserved.
  - [22] WR: 1 = write, 0 = read.
  - [23] reserved.
  - [31:24] header; must equal `HDR`.
  - [47:32] write data. Ignored on reads.
- Slave FSM: IDLE -> ADDR (bits 0-31 received) -> DATA (bits 32-47) -> DONE.
  - The FSM returns to IDLE on `spi_cs_n` rising edge.
- Header check, after bit 31:
  - Mismatch: pulse `frame_err`, hold MISO at 0 for the rest of the frame, issue no APB access.
- Read path:
  - After bit 31 with a valid header and WR=0, an APB read to the address is issued immediately.
  - The read data is latched.
  - MISO drives read data bits 0..15 during frame bits 32..47, LSB first.
  - `frame_done` pulses after bit 47.
- Write path:
  - After bit 47 is sampled with a valid header and WR=1, an APB write of [47:32] to the address is issued.
  - `frame_done` pulses after the write.
  - MISO is 0 throughout a write frame.
- Internal APB master:
  - Phases: SETUP (PSEL=1, PENABLE=0), then ACCESS (PENABLE=1), then complete on PREADY.
  - The register map always returns PREADY=1 in ACCESS and PSLVERR=0.
- Abort:
  - `spi_cs_n` deasserted before bit 47 aborts the frame: no write, `frame_err` pulses.
  - A read already issued completes, but its data is discarded.
  - Bits beyond 48 are ignored. MISO returns to 0.
- Reset:
  - Clears the FSM, bit counter, shift registers and APB signals.
  - Memory contents are not cleared.

## Timing
- Requirement: SCLK half-period ≥ 8 `clk` cycles.
  - This guarantees the read completes before the bit-32 falling edge: 2-cycle sync + 2-cycle APB + latch.
- Read latency: APB SETUP begins 3 `clk` cycles after the synchronized SCLK rising edge of bit 31. Data is valid 2 cycles later.
- Write: APB SETUP begins 3 cycles after the bit-47 synchronized rising edge and completes 2 cycles later.
- Back-to-back frames: CS_N high time ≥ 4 `clk` cycles. The write of the previous frame has committed before the next frame's bit 0.
- Reset mid-frame: the frame is lost; the FSM waits for the next `spi_cs_n` falling edge.

## Test plan
- Write then read, with `USE_MEM`=1:
  - Write frame 48'hccdf_1745ad01, then read frame 48'hccdf_1705ad01.
  - MISO returns 16'hccdf; address 20'h5ad01 holds 16'hccdf.
- Bad header:
  - Write frame 48'h1234_1845ad01; `frame_err` pulses.
  - A later read of 20'h5ad01 returns the previous value.
- Short frame:
  - Write 48'hbeef_1745ad02 with CS_N raised after 40 bits.
  - No write occurs (address reads its prior value); `frame_err` pulses.
- `USE_MEM`=0:
  - Write 16'ha5a5 to 20'h0001f; read returns 16'ha5a5.
  - Write to 20'h00020; read returns 16'h0000.
- Back-to-back writes to the same address, 16'hdead then 16'hdaad, with minimum CS_N gap: read returns 16'hdaad.
- Reset asserted mid-frame at bit 20, then a full read of 20'h5ad01: the correct value is returned and all outputs were 0 during reset.
